// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared op/state encodings and constants for the MEM-stage access controller
package mem_access_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'b0000,
        OP_LBU = 4'b0001,
        OP_LH  = 4'b0010,
        OP_LHU = 4'b0011,
        OP_LW  = 4'b0100,
        OP_LL  = 4'b0101,
        OP_SB  = 4'b1000,
        OP_SH  = 4'b1001,
        OP_SW  = 4'b1010,
        OP_SC  = 4'b1011
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Access width of an op; invalid encodings fall into the word bucket and are rejected elsewhere.
    function automatic size_e op_size(input logic [3:0] op);
        size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian byte-lane steering for stores and load extract/extend
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  sel,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte enables and replicated store data; offset 0 is the most significant lane.
    always_comb begin
        sel         = 4'b1111;
        wdata_lanes = wdata;
        case (op_size(op))
            SZ_BYTE: begin
                sel         = 4'b1000 >> offset;
                wdata_lanes = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                sel         = offset[1] ? 4'b0011 : 4'b1100;
                wdata_lanes = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed byte out of the returned word.
    always_comb begin
        byte_sel = rdata_raw[7:0];
        case (offset)
            2'd0:    byte_sel = rdata_raw[31:24];
            2'd1:    byte_sel = rdata_raw[23:16];
            2'd2:    byte_sel = rdata_raw[15:8];
            default: byte_sel = rdata_raw[7:0];
        endcase
    end

    assign half_sel = offset[1] ? rdata_raw[15:0] : rdata_raw[31:16];

    // Sign- or zero-extend the picked byte/halfword; word loads pass straight through.
    always_comb begin
        rdata_ext = rdata_raw;
        case (op)
            OP_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  rdata_ext = {24'h0, byte_sel};
            OP_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  rdata_ext = {16'h0, half_sel};
            default: rdata_ext = rdata_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store controller; LL_SC_EN enables LL/SC with an llbit
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              flush_i,
    output logic              ack_o,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_rdy_i
);

    state_e      state_q, state_d;
    logic        hold_q;
    logic [31:0] rdata_q;
    logic        adel_q, ades_q;
    logic        op_valid, is_store, misaligned, sc_fail, start;
    size_e       size;
    logic [3:0]  sel_w;
    logic [31:0] wdata_w, rdata_ext_w;

    mem_lane_align u_lane (
        .op          (op_i),
        .offset      (addr_i[1:0]),
        .wdata       (wdata_i),
        .rdata_raw   (mem_data_i),
        .sel         (sel_w),
        .wdata_lanes (wdata_w),
        .rdata_ext   (rdata_ext_w)
    );

    // Decode which op encodings are legal in this build.
    always_comb begin
        case (op_i)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: op_valid = ENABLE;
`ifdef LL_SC_EN
            OP_LL, OP_SC: op_valid = ENABLE;
`endif
            default: op_valid = DISABLE;
        endcase
    end

    assign is_store   = op_i[3];
    assign size       = op_size(op_i);
    assign misaligned = op_valid & (((size == SZ_HALF) & addr_i[0]) |
                                    ((size == SZ_WORD) & (addr_i[1:0] != 2'b00)));
    // A request that already completed stays blocked until req_i drops.
    assign start      = req_i & ~hold_q;

`ifdef LL_SC_EN
    logic llbit_q;
    assign sc_fail = (op_i == OP_SC) & ~llbit_q;

    // Link bit: set by a completed LL, consumed by a completed SC, lost on any flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            llbit_q <= DISABLE;
        end else if (flush_i) begin
            llbit_q <= DISABLE;
        end else if (state_q == ST_ACCESS && state_d == ST_DONE) begin
            if (op_i == OP_LL)      llbit_q <= ENABLE;
            else if (op_i == OP_SC) llbit_q <= DISABLE;
        end
    end
`else
    assign sc_fail = DISABLE;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake outputs; flush beats every transition.
    always_comb begin
        state_d = state_q;
        ack_o   = DISABLE;
        adel_o  = DISABLE;
        ades_o  = DISABLE;
        stall_o = DISABLE;
        case (state_q)
            ST_IDLE: begin
                stall_o = start;
                if (!flush_i && start)
                    state_d = (op_valid && !misaligned && !sc_fail) ? ST_ACCESS : ST_DONE;
            end
            ST_ACCESS: begin
                stall_o = ENABLE;
                if (flush_i)        state_d = ST_IDLE;
                else if (mem_rdy_i) state_d = ST_DONE;
            end
            default: begin
                ack_o   = ENABLE;
                adel_o  = adel_q;
                ades_o  = ades_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory port: loaded when entering ACCESS, held through wait states, cleared otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ce_o   <= DISABLE;
            mem_we_o   <= DISABLE;
            mem_addr_o <= '0;
            mem_sel_o  <= 4'b0000;
            mem_data_o <= ZERO_WORD;
        end else if (state_d == ST_ACCESS) begin
            if (state_q == ST_IDLE) begin
                mem_ce_o   <= ENABLE;
                mem_we_o   <= is_store;
                mem_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
                mem_sel_o  <= sel_w;
                mem_data_o <= is_store ? wdata_w : ZERO_WORD;
            end
        end else begin
            mem_ce_o   <= DISABLE;
            mem_we_o   <= DISABLE;
            mem_addr_o <= '0;
            mem_sel_o  <= 4'b0000;
            mem_data_o <= ZERO_WORD;
        end
    end

    // Completion result, captured on the edge into DONE and held until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= ZERO_WORD;
            adel_q  <= DISABLE;
            ades_q  <= DISABLE;
        end else if (state_d == ST_DONE) begin
            if (state_q == ST_ACCESS) begin
                rdata_q <= is_store ? {31'b0, (op_i == OP_SC)} : rdata_ext_w;
                adel_q  <= DISABLE;
                ades_q  <= DISABLE;
            end else begin
                rdata_q <= ZERO_WORD;
                adel_q  <= misaligned & ~is_store;
                ades_q  <= misaligned & is_store;
            end
        end
    end

    // Remember that the current request has been answered until the pipeline drops req_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                hold_q <= DISABLE;
        else if (!req_i)           hold_q <= DISABLE;
        else if (state_d == ST_DONE) hold_q <= ENABLE;
    end

    assign rdata_o = rdata_q;

endmodule
